// File: rtl/hv_wd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hv_wd_pkg
//  Description : Shared state encodings and default timing parameters for the
//                HV watchdog supervisor.
//  Revision    : 1.0 - initial release
// ============================================================================
package hv_wd_pkg;

   // Default timing: missed ticks before warning/trip, discharge hold cycles
   localparam int unsigned C_WARN_TICKS_DEF = 4;
   localparam int unsigned C_TRIP_TICKS_DEF = 8;
   localparam int unsigned C_DIS_CYC_DEF    = 16;

   // Supervisor states, encoding is visible on the state output
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_WARN = 2'd2,
      ST_TRIP = 2'd3
   } hv_wd_state_e;

endpackage : hv_wd_pkg
`default_nettype wire

// File: rtl/hv_wd_dis_timer.sv
`default_nettype none
// ============================================================================
//  Module      : hv_wd_dis_timer
//  Description : 8-bit discharge down-counter. Loaded on trip entry, counts
//                down to zero and flags done while at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module hv_wd_dis_timer
   import hv_wd_pkg::*;
(
   input  logic       adc_clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic       done
);

   logic [7:0] r_count;

   // Load has priority; otherwise count down and park at zero
   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 8'd0;
      end else if (load) begin
         r_count <= load_val;
      end else if (r_count != 8'd0) begin
         r_count <= r_count - 8'd1;
      end
   end

   assign done = (r_count == 8'd0);

endmodule : hv_wd_dis_timer
`default_nettype wire

// File: rtl/hv_wd_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : hv_wd_supervisor
//  Description : HV enable supervisor. Counts watchdog ticks without a
//                firmware kick, warns, then trips HV off with a timed
//                discharge and a sticky fault that needs a gated clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module hv_wd_supervisor
   import hv_wd_pkg::*;
#(
   parameter int unsigned WARN_TICKS = C_WARN_TICKS_DEF,
   parameter int unsigned TRIP_TICKS = C_TRIP_TICKS_DEF,
   parameter int unsigned DIS_CYC    = C_DIS_CYC_DEF
)(
   input  logic       adc_clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       arm,
   input  logic       kick,
   input  logic       clr_fault,
   output logic       hv_en,
   output logic       warn,
   output logic       fault,
   output logic       discharge,
   output logic [1:0] state,
   output logic [3:0] miss_cnt,
   output logic [7:0] trip_cnt
);

   localparam logic [3:0] C_WARN    = 4'(WARN_TICKS);
   localparam logic [3:0] C_TRIP    = 4'(TRIP_TICKS);
   localparam logic [7:0] C_DIS_LD  = 8'(DIS_CYC - 1);

   hv_wd_state_e r_state;
   logic [3:0]   r_miss;
   logic [7:0]   r_trip_cnt;
   logic         r_hv_en;
   logic         r_warn;
   logic         r_fault;
   logic         r_discharge;

   logic [3:0]   w_miss_inc;
   logic         w_trip_entry;
   logic         w_dis_done;

   // Candidate miss count for a tick without kick (never overflows: miss < TRIP <= 15)
   assign w_miss_inc   = r_miss + 4'd1;
   // Same condition the FSM uses to enter TRIP; drives the timer load
   assign w_trip_entry = (r_state == ST_WARN) && arm && !kick && tick && (w_miss_inc == C_TRIP);

   hv_wd_dis_timer u_dis_timer (
      .adc_clk  (adc_clk),
      .rst_n    (rst_n),
      .load     (w_trip_entry),
      .load_val (C_DIS_LD),
      .done     (w_dis_done)
   );

   // Supervisor FSM with all outputs registered alongside the state
   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_miss      <= 4'd0;
         r_trip_cnt  <= 8'd0;
         r_hv_en     <= 1'b0;
         r_warn      <= 1'b0;
         r_fault     <= 1'b0;
         r_discharge <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_miss <= 4'd0;
               if (arm) begin
                  r_state <= ST_RUN;
                  r_hv_en <= 1'b1;
               end
            end
            ST_RUN, ST_WARN: begin
               if (!arm) begin
                  // Disarm wins over everything and is not a fault
                  r_state <= ST_IDLE;
                  r_miss  <= 4'd0;
                  r_hv_en <= 1'b0;
                  r_warn  <= 1'b0;
               end else if (kick) begin
                  r_state <= ST_RUN;
                  r_miss  <= 4'd0;
                  r_warn  <= 1'b0;
               end else if (tick) begin
                  r_miss <= w_miss_inc;
                  if (r_state == ST_RUN && w_miss_inc == C_WARN) begin
                     r_state <= ST_WARN;
                     r_warn  <= 1'b1;
                  end else if (w_trip_entry) begin
                     r_state     <= ST_TRIP;
                     r_hv_en     <= 1'b0;
                     r_warn      <= 1'b0;
                     r_fault     <= 1'b1;
                     r_discharge <= 1'b1;
                     if (r_trip_cnt != 8'hFF) begin
                        r_trip_cnt <= r_trip_cnt + 8'd1;
                     end
                  end
               end
            end
            ST_TRIP: begin
               // Timer reaching zero ends the discharge window
               if (r_discharge && w_dis_done) begin
                  r_discharge <= 1'b0;
               end
               // Clear only once discharged and disarmed; otherwise dropped
               if (clr_fault && !r_discharge && !arm) begin
                  r_state <= ST_IDLE;
                  r_fault <= 1'b0;
                  r_miss  <= 4'd0;
               end
            end
         endcase
      end
   end

   assign state     = r_state;
   assign miss_cnt  = r_miss;
   assign trip_cnt  = r_trip_cnt;
   assign hv_en     = r_hv_en;
   assign warn      = r_warn;
   assign fault     = r_fault;
   assign discharge = r_discharge;

endmodule : hv_wd_supervisor
`default_nettype wire
